// File: rtl/operand_forward_scoreboard_pkg.sv
// rtl/operand_forward_scoreboard_pkg.sv - shared types, constants and tag helpers for the forwarding scoreboard
package fwd_scoreboard_types;

    localparam int REG_W    = 5;
    localparam int TAG_NONE = 0;

    // Which register update the top performs this cycle
    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_BUBBLE = 2'd1,
        UPD_AGE    = 2'd2
    } upd_t;

    // Width of a forwarding tag: NONE + every stage + every buffer slot
    function automatic int tag_width(input int pipe_depth, input int num_buf);
        return $clog2(pipe_depth + num_buf + 1);
    endfunction

    function automatic int stage_tag(input int k);
        return 1 + k;
    endfunction

    function automatic int buf_tag(input int j, input int pipe_depth);
        return 1 + pipe_depth + j;
    endfunction

    // One cycle of ageing: move one slot further from EX, saturating at the last buffer slot
    function automatic int tag_age(input int t, input int pipe_depth, input int num_buf);
        if (t == TAG_NONE) begin
            return t;
        end
        if (t < buf_tag(num_buf - 1, pipe_depth)) begin
            return t + 1;
        end
        return t;
    endfunction

endpackage

// File: rtl/operand_forward_scoreboard_src_match.sv
// rtl/operand_forward_scoreboard_src_match.sv - youngest-producer search and load-use hazard for one operand
module fwd_src_match
    import fwd_scoreboard_types::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int TAG_W      = 3
) (
    input  logic                          src_valid,
    input  logic [REG_W-1:0]              src_reg,
    input  logic [PIPE_DEPTH-1:0]         stg_valid,
    input  logic [PIPE_DEPTH*REG_W-1:0]   stg_rd,
    input  logic [PIPE_DEPTH-1:0]         stg_wr_rd,
    input  logic [PIPE_DEPTH-1:0]         stg_late,
    input  logic [PIPE_DEPTH-1:0]         stg_ready,
    output logic [TAG_W-1:0]              tag_d,
    output logic                          hazard
);

    // Scan oldest to youngest so the lowest matching stage overwrites and wins; x0 never matches
    always_comb begin
        tag_d  = TAG_W'(TAG_NONE);
        hazard = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (src_valid && (src_reg != '0) && stg_valid[k] && stg_wr_rd[k] &&
                (stg_rd[k*REG_W +: REG_W] == src_reg)) begin
                tag_d  = TAG_W'(stage_tag(k));
                hazard = stg_late[k] && !stg_ready[k];
            end
        end
    end

endmodule

// File: rtl/operand_forward_scoreboard.sv
// rtl/operand_forward_scoreboard.sv - decode-stage forwarding tag tracker with load-use stall and tag ageing
module operand_forward_scoreboard
    import fwd_scoreboard_types::*;
#(
    parameter  int NUM_SRC    = 2,
    parameter  int PIPE_DEPTH = 3,
    parameter  int NUM_BUF    = 1,
    parameter  int CNT_W      = 32,
    localparam int TAG_W      = tag_width(PIPE_DEPTH, NUM_BUF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*REG_W-1:0]      src_reg,
    input  logic [PIPE_DEPTH-1:0]         stg_valid,
    input  logic [PIPE_DEPTH*REG_W-1:0]   stg_rd,
    input  logic [PIPE_DEPTH-1:0]         stg_wr_rd,
    input  logic [PIPE_DEPTH-1:0]         stg_late,
    input  logic [PIPE_DEPTH-1:0]         stg_ready,
    input  logic                          stall_in,
    output logic                          out_valid,
    output logic [NUM_SRC*TAG_W-1:0]      fwd_tag,
    output logic                          stall_out,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic                          buf_overflow
);

    logic [NUM_SRC*TAG_W-1:0] tag_d;
    logic [NUM_SRC*TAG_W-1:0] tag_aged;
    logic [NUM_SRC-1:0]       hazard;
    logic                     age_ovf;
    upd_t                     upd;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .TAG_W      (TAG_W)
        ) u_match (
            .src_valid (src_valid[i]),
            .src_reg   (src_reg[i*REG_W +: REG_W]),
            .stg_valid (stg_valid),
            .stg_rd    (stg_rd),
            .stg_wr_rd (stg_wr_rd),
            .stg_late  (stg_late),
            .stg_ready (stg_ready),
            .tag_d     (tag_d[i*TAG_W +: TAG_W]),
            .hazard    (hazard[i])
        );
    end

    // A load-use hazard only matters for a real instruction; a downstream hold always freezes decode
    assign stall_out = stall_in | (in_valid & (|hazard));

    // Downstream hold takes precedence over a bubble so the latched instruction is never lost
    always_comb begin
        if (!stall_out) begin
            upd = UPD_LOAD;
        end else if (!stall_in) begin
            upd = UPD_BUBBLE;
        end else begin
            upd = UPD_AGE;
        end
    end

    // Next tags while held, and whether any tag is already parked in the last buffer slot
    always_comb begin
        tag_aged = '0;
        age_ovf  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            tag_aged[i*TAG_W +: TAG_W] =
                TAG_W'(tag_age(int'(fwd_tag[i*TAG_W +: TAG_W]), PIPE_DEPTH, NUM_BUF));
            if (int'(fwd_tag[i*TAG_W +: TAG_W]) == buf_tag(NUM_BUF - 1, PIPE_DEPTH)) begin
                age_ovf = 1'b1;
            end
        end
    end

    // Latched decode outputs, saturating stall counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            fwd_tag      <= '0;
            stall_cycles <= '0;
            buf_overflow <= 1'b0;
        end else begin
            if (stall_out && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            case (upd)
                UPD_LOAD: begin
                    out_valid <= in_valid;
                    fwd_tag   <= tag_d;
                end
                UPD_BUBBLE: begin
                    out_valid <= 1'b0;
                    fwd_tag   <= '0;
                end
                default: begin
                    fwd_tag <= tag_aged;
                    if (age_ovf) begin
                        buf_overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
